// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg
// Shared types, constants and helpers for the latch bank write sequencer.
//   lbw_state_t  : sequencer state (IDLE, SETUP, PULSE, HOLD), 2-bit encoding
//   PULSE_CNT_W  : width of the enable-pulse down-counter
//   MAX_ROWS     : widest row-enable vector that onehot() can build
//   PAR_BITS     : 1 when the parity column is built (macro LBW_PARITY_EN), else 0
//   onehot()     : row-enable vector for an address, all-zero when out of range
//   in_range()   : true when an address selects an existing row
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } lbw_state_t;

  localparam int PULSE_CNT_W = 4;
  localparam int MAX_ROWS    = 64;

`ifdef LBW_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic logic in_range(input int addr, input int rows);
    return (addr >= 0) && (addr < rows);
  endfunction

  // A shift is used instead of an indexed write so out-of-range indices can
  // never address past the vector; callers truncate to their own row count.
  function automatic logic [MAX_ROWS-1:0] onehot(input int addr, input int rows);
    logic [MAX_ROWS-1:0] vec;
    vec = '0;
    if (in_range(addr, rows)) begin
      vec = MAX_ROWS'(1) << addr;
    end
    return vec;
  endfunction

endpackage

// File: rtl/lbw_pulse_timer.sv
// lbw_pulse_timer
// Loadable down-counter that times the latch enable pulse.
//   CLK      in  rising-edge clock
//   RN       in  async active-low reset
//   load     in  load load_val into the counter
//   dec      in  count down by one (ignored while load is high or count is 0)
//   load_val in  pulse length in cycles (1..15)
//   expire   out high during the last cycle of the pulse (count == 1)
module lbw_pulse_timer
  import latch_bank_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RN,
  input  logic                   load,
  input  logic                   dec,
  input  logic [PULSE_CNT_W-1:0] load_val,
  output logic                   expire
);

  logic [PULSE_CNT_W-1:0] count;

  // Load wins over decrement; the counter parks at zero between pulses.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - PULSE_CNT_W'(1);
    end
  end

  // Expiring on count==1 lets the owner leave PULSE on the same edge the
  // final enable cycle ends, giving exactly load_val cycles of enable.
  assign expire = (count == PULSE_CNT_W'(1));

endmodule

// File: rtl/latch_bank_writer.sv
// latch_bank_writer
// Write sequencer feeding a bank of D-latches. Each accepted {addr,data}
// word is driven onto the shared D bus, followed by one setup cycle, a
// PULSE_CYC-cycle one-hot enable pulse and one hold cycle. Enables come
// straight from flops so they are glitch-free on latch clock pins.
// Optional build macro: LBW_PARITY_EN adds an even-parity column lat_d[WIDTH].
//   CLK      in  rising-edge clock
//   RN       in  async active-low reset
//   in_valid in  write request valid
//   in_ready out request accepted this edge (high only in IDLE)
//   in_addr  in  target row
//   in_data  in  row data
//   lat_d    out shared latch D bus (WIDTH, or WIDTH+1 with parity)
//   lat_en   out one-hot active-high latch enables
//   busy     out write in progress
//   done     out one-cycle pulse as the write completes
//   addr_err out sticky: a request addressed a non-existent row
module latch_bank_writer
  import latch_bank_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int ROWS      = 4,
  parameter  int PULSE_CYC = 1,
  localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int DW        = WIDTH + PAR_BITS
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic [DW-1:0]    lat_d,
  output logic [ROWS-1:0]  lat_en,
  output logic             busy,
  output logic             done,
  output logic             addr_err
);

  lbw_state_t    state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] next_d;
  logic          pulse_expire;

`ifdef LBW_PARITY_EN
  assign next_d = {^in_data, in_data};
`else
  assign next_d = in_data;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  lbw_pulse_timer u_timer (
    .CLK      (CLK),
    .RN       (RN),
    .load     (state == SETUP),
    .dec      (state == PULSE),
    .load_val (PULSE_CNT_W'(PULSE_CYC)),
    .expire   (pulse_expire)
  );

  // Sequencer. lat_d is only written in IDLE, so it cannot move while an
  // enable is open or during the setup/hold margins. An out-of-range row
  // still walks the whole sequence so done timing stays uniform; onehot()
  // just yields no enable.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      addr_q   <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q <= in_addr;
            lat_d  <= next_d;
            state  <= SETUP;
            if (!in_range(int'(in_addr), ROWS)) begin
              addr_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          lat_en <= ROWS'(onehot(int'(addr_q), ROWS));
          state  <= PULSE;
        end
        PULSE: begin
          if (pulse_expire) begin
            lat_en <= '0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer
// Bench for latch_bank_writer with two instances: dut_a (ROWS=4, PULSE_CYC=1)
// and dut_b (ROWS=5, PULSE_CYC=3). A cycle-level reference model tracks each
// write by "cycles since accept" and is compared every cycle; directed table
// vectors and sequences cover timing, back-to-back, range errors and reset.
module tb_latch_bank_writer;

`ifdef LBW_PARITY_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif

  logic CLK = 1'b0;
  logic RN  = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic          va = 1'b0, vb = 1'b0;
  logic [1:0]    aa = '0;
  logic [2:0]    ab = '0;
  logic [7:0]    da = '0, db = '0;
  logic          ready_a, busy_a, done_a, err_a;
  logic          ready_b, busy_b, done_b, err_b;
  logic [DW-1:0] latd_a, latd_b;
  logic [3:0]    en_a;
  logic [4:0]    en_b;

  latch_bank_writer #(.WIDTH(8), .ROWS(4), .PULSE_CYC(1)) dut_a (
    .CLK(CLK), .RN(RN), .in_valid(va), .in_ready(ready_a), .in_addr(aa),
    .in_data(da), .lat_d(latd_a), .lat_en(en_a), .busy(busy_a),
    .done(done_a), .addr_err(err_a)
  );

  latch_bank_writer #(.WIDTH(8), .ROWS(5), .PULSE_CYC(3)) dut_b (
    .CLK(CLK), .RN(RN), .in_valid(vb), .in_ready(ready_b), .in_addr(ab),
    .in_data(db), .lat_d(latd_b), .lat_en(en_b), .busy(busy_b),
    .done(done_b), .addr_err(err_b)
  );

  // Reference model: t = clock edges since the accepting edge.
  // t=0 setup, 1..P enable open, P+1 hold, P+2 done pulse and idle again.
  typedef struct {
    bit            active;
    int            t;
    logic [DW-1:0] d;
    int            addr;
    bit            err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic logic [DW-1:0] exp_word(input logic [7:0] data);
`ifdef LBW_PARITY_EN
    return {^data, data};
`else
    return data;
`endif
  endfunction

  function automatic bit mdl_busy(input mdl_t m, input int p);
    return m.active && (m.t <= p + 1);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit valid, input int addr,
                                    input logic [7:0] data, input int p, input int rows);
    mdl_t n = m;
    if (!mdl_busy(m, p) && valid) begin
      n.active = 1'b1;
      n.t      = 0;
      n.d      = exp_word(data);
      n.addr   = addr;
      if (addr >= rows) n.err = 1'b1;
    end else if (m.active && m.t < 1000) begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  function automatic int mdl_en(input mdl_t m, input int p, input int rows);
    if (m.active && m.t >= 1 && m.t <= p && m.addr < rows) return 1 << m.addr;
    return 0;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.active = 1'b0;
    m.t      = 0;
    m.d      = '0;
    m.addr   = 0;
    m.err    = 1'b0;
    return m;
  endfunction

  always @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, va, int'(aa), da, 1, 4);
      mb <= mdl_step(mb, vb, int'(ab), db, 3, 5);
    end
  end

  // Every-cycle comparison of both instances against the model, plus a
  // D-bus stability check across any cycle that had an enable open.
  logic [DW-1:0] pd_a = '0, pd_b = '0;
  logic [3:0]    pe_a = '0;
  logic [4:0]    pe_b = '0;

  always @(negedge CLK) begin
    if (RN) begin
      checks++;
      if (ready_a !== !mdl_busy(ma, 1) || busy_a !== mdl_busy(ma, 1) ||
          done_a !== (ma.active && ma.t == 3) || err_a !== ma.err ||
          32'(en_a) !== mdl_en(ma, 1, 4) || latd_a !== ma.d) begin
        errors++;
        $display("[TB] FAIL model_a @%0t: got rdy=%b busy=%b done=%b err=%b en=%b d=%h, expected t=%0d err=%b en=%0h d=%h",
                 $time, ready_a, busy_a, done_a, err_a, en_a, latd_a, ma.t, ma.err, mdl_en(ma, 1, 4), ma.d);
      end
      checks++;
      if (ready_b !== !mdl_busy(mb, 3) || busy_b !== mdl_busy(mb, 3) ||
          done_b !== (mb.active && mb.t == 5) || err_b !== mb.err ||
          32'(en_b) !== mdl_en(mb, 3, 5) || latd_b !== mb.d) begin
        errors++;
        $display("[TB] FAIL model_b @%0t: got rdy=%b busy=%b done=%b err=%b en=%b d=%h, expected t=%0d err=%b en=%0h d=%h",
                 $time, ready_b, busy_b, done_b, err_b, en_b, latd_b, mb.t, mb.err, mdl_en(mb, 3, 5), mb.d);
      end
      if (pe_a != 0) begin
        checks++;
        if (latd_a !== pd_a) begin
          errors++;
          $display("[TB] FAIL stable_a: lat_d %h, required %h while enable open", latd_a, pd_a);
        end
      end
      if (pe_b != 0) begin
        checks++;
        if (latd_b !== pd_b) begin
          errors++;
          $display("[TB] FAIL stable_b: lat_d %h, required %h while enable open", latd_b, pd_b);
        end
      end
      pd_a <= latd_a;
      pd_b <= latd_b;
      pe_a <= en_a;
      pe_b <= en_b;
    end else begin
      pe_a <= '0;
      pe_b <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Present a request and return #1 after the accepting edge (t=0).
  task automatic write_a(input logic [1:0] a, input logic [7:0] d, output bit ok);
    bit acc;
    ok = 1'b0;
    va = 1'b1; aa = a; da = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      acc = ready_a;
      @(posedge CLK); #1;
      ok = acc;
    end
    va = 1'b0;
    chk("accept_a", 32'(ok), 32'd1);
  endtask

  task automatic write_b(input logic [2:0] a, input logic [7:0] d, output bit ok);
    bit acc;
    ok = 1'b0;
    vb = 1'b1; ab = a; db = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      acc = ready_b;
      @(posedge CLK); #1;
      ok = acc;
    end
    vb = 1'b0;
    chk("accept_b", 32'(ok), 32'd1);
  endtask

  // Follow a dut_b write from t=0; report enable-high count, the enable
  // value seen and the t at which done pulsed.
  task automatic track_b(output int n_en, output int en_seen, output int done_t);
    n_en = 0; en_seen = 0; done_t = -1;
    for (int t = 1; t <= 10 && done_t < 0; t++) begin
      @(posedge CLK); #1;
      if (en_b != 0) begin
        n_en++;
        en_seen = 32'(en_b);
      end
      if (done_b) done_t = t;
    end
  endtask

  typedef struct {
    logic [1:0]    addr;
    logic [7:0]    data;
    logic [3:0]    exp_en;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int n_en, en_seen, done_t, edges;

    vecs[0] = '{2'd2, 8'hA5, 4'b0100, DW'(9'h0A5)};
    vecs[1] = '{2'd0, 8'h11, 4'b0001, DW'(9'h011)};
    vecs[2] = '{2'd3, 8'hEE, 4'b1000, DW'(9'h0EE)};
    vecs[3] = '{2'd1, 8'h5A, 4'b0010, DW'(9'h05A)};
`ifdef LBW_PARITY_EN
    vecs[4] = '{2'd1, 8'h07, 4'b0010, DW'(9'h107)};
`else
    vecs[4] = '{2'd1, 8'h07, 4'b0010, DW'(9'h007)};
`endif
    vecs[5] = '{2'd0, 8'h03, 4'b0001, DW'(9'h003)};

    // Reset state
    #1 RN = 1'b0;
    #3;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_en",    32'(en_a),    32'd0);
    chk("rst_d",     32'(latd_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_err",   32'(err_b),   32'd0);
    repeat (2) @(negedge CLK);
    #2 RN = 1'b1;

    // Table vectors: exact per-cycle timing for PULSE_CYC=1
    foreach (vecs[i]) begin
      write_a(vecs[i].addr, vecs[i].data, ok);
      chk("vec_d_setup",  32'(latd_a), 32'(vecs[i].exp_d));
      chk("vec_en_setup", 32'(en_a),   32'd0);
      @(posedge CLK); #1;
      chk("vec_en_pulse", 32'(en_a),   32'(vecs[i].exp_en));
      @(posedge CLK); #1;
      chk("vec_en_hold",  32'(en_a),   32'd0);
      chk("vec_d_hold",   32'(latd_a), 32'(vecs[i].exp_d));
      @(posedge CLK); #1;
      chk("vec_done",     32'(done_a), 32'd1);
      chk("vec_ready",    32'(ready_a), 32'd1);
    end

    // Back-to-back with valid held: second accept one cycle after done
    write_a(2'd0, 8'h11, ok);
    va = 1'b1; aa = 2'd3; da = 8'hEE;
    edges = 0;
    for (int i = 0; i < 12 && !(busy_a && latd_a === DW'(9'h0EE)); i++) begin
      @(posedge CLK); #1;
      edges++;
    end
    va = 1'b0;
    chk("b2b_period", 32'(edges), 32'd4);
    @(posedge CLK); #1;
    chk("b2b_en", 32'(en_a), 32'b1000);

    repeat (4) @(posedge CLK);
    #1;

    // PULSE_CYC=3 on dut_b: three enable cycles, done at t=5
    write_b(3'd1, 8'h3C, ok);
    track_b(n_en, en_seen, done_t);
    chk("p3_en_cycles", 32'(n_en), 32'd3);
    chk("p3_en_value",  32'(en_seen), 32'b00010);
    chk("p3_done_t",    32'(done_t), 32'd5);

    // Out-of-range row: no enable, sticky error, done still pulses
    write_b(3'd7, 8'h55, ok);
    track_b(n_en, en_seen, done_t);
    chk("oor_en_cycles", 32'(n_en), 32'd0);
    chk("oor_done_t",    32'(done_t), 32'd5);
    chk("oor_err",       32'(err_b), 32'd1);
    write_b(3'd4, 8'h99, ok);
    track_b(n_en, en_seen, done_t);
    chk("after_oor_en",  32'(en_seen), 32'b10000);
    chk("after_oor_cyc", 32'(n_en), 32'd3);
    chk("err_sticky",    32'(err_b), 32'd1);

    // Randomized traffic, checked by the per-cycle model
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      va = 1'($urandom_range(0, 1));
      aa = 2'($urandom_range(0, 3));
      da = 8'($urandom);
      vb = 1'($urandom_range(0, 1));
      ab = 3'($urandom_range(0, 7));
      db = 8'($urandom);
    end
    va = 1'b0; vb = 1'b0;
    repeat (8) @(posedge CLK);
    #1;

    // Reset in the middle of an enable pulse
    write_a(2'd1, 8'h5A, ok);
    @(posedge CLK); #1;
    chk("midrst_pre_en", 32'(en_a), 32'b0010);
    #2 RN = 1'b0;
    #1;
    chk("midrst_en",   32'(en_a),   32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_err",  32'(err_b),  32'd0);
    @(negedge CLK);
    #2 RN = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_ready", 32'(ready_a), 32'd1);
    chk("midrst_en2",   32'(en_a),    32'd0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
